// File: rtl/xor_aoig_stream.sv
// rtl/xor_aoig_stream.sv - registered XOR/XNOR/rotate-XOR/accumulate stream unit with 1-entry skid buffer
// XOR bits are formed as (~a&b)|(a&~b); the result is registered behind a valid/ready handshake.
module xor_aoig_stream #(
   parameter int WIDTH = 16,
   parameter int ROT_B = 2,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in0,
   input  logic [WIDTH-1:0] i_in1,
   input  logic [1:0]       i_mode,
   input  logic             i_acc_clr,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [CNT_W-1:0] o_xfer_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] f_aoig_xor(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      f_aoig_xor = (~a & b) | (a & ~b);
   endfunction

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_rot;
   logic [WIDTH-1:0] w_ab;
   logic [WIDTH-1:0] w_acc_eff;
   logic [WIDTH-1:0] w_f;
   logic             w_accept;
   logic             w_hs;

   // Left rotate by ROT_B: output bit i takes input bit (i - ROT_B) mod WIDTH.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_rot
         assign w_rot[gi] = i_in1[(gi + WIDTH - ROT_B) % WIDTH];
      end
   endgenerate

   assign w_ab      = f_aoig_xor(i_in0, i_in1);
   assign w_acc_eff = i_acc_clr ? '0 : r_acc;
   assign w_accept  = i_in_valid & r_in_ready;
   assign w_hs      = r_out_valid & i_out_ready;

   always_comb begin
      w_f = w_ab;
      case (i_mode)
         2'd0:    w_f = w_ab;
         2'd1:    w_f = ~w_ab;
         2'd2:    w_f = f_aoig_xor(i_in0, w_rot);
         default: w_f = f_aoig_xor(w_acc_eff, w_ab);
      endcase
   end

   // Output register O plus skid register S; in_ready is registered so it drops only in FULL.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_skid      <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_out_data  <= w_f;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_hs) begin
                  r_out_data <= w_f;
               end else if (w_accept) begin
                  r_skid     <= w_f;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_FULL;
               end else if (w_hs) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_hs) begin
                  r_out_data <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // A clear with a mode-3 accept is already folded into w_f through w_acc_eff.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= '0;
      end else if (w_accept && (i_mode == 2'd3)) begin
         r_acc <= w_f;
      end else if (i_acc_clr) begin
         r_acc <= '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_hs) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_xor_aoig_stream.sv
// tb/tb_xor_aoig_stream.sv - self-checking bench for xor_aoig_stream
// Directed vector table, back-pressure/wrap/reset sequences, and a randomized run against a queue model.
module tb_xor_aoig_stream;

   localparam int W     = 16;
   localparam int ROT   = 2;
   localparam int CNT_W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic           acc_clr = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [W-1:0]   in0 = '0;
   logic [W-1:0]   in1 = '0;
   logic           o_in_ready;
   logic           o_out_valid;
   logic [W-1:0]   o_out_data;
   logic [CNT_W-1:0] o_xfer_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] delivered[$];
   logic [W-1:0] macc = '0;
   int           mcnt = 0;

   typedef struct {
      logic         valid;
      logic [1:0]   mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         clr;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl[8];

   xor_aoig_stream #(.WIDTH(W), .ROT_B(ROT), .CNT_W(CNT_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_valid (in_valid),
      .o_in_ready (o_in_ready),
      .i_in0      (in0),
      .i_in1      (in1),
      .i_mode     (mode),
      .i_acc_clr  (acc_clr),
      .o_out_valid(o_out_valid),
      .i_out_ready(out_ready),
      .o_out_data (o_out_data),
      .o_xfer_cnt (o_xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_f(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic clr);
      logic [2*W-1:0] t;
      t = {b, b} << ROT;
      case (m)
         2'd0:    return a ^ b;
         2'd1:    return ~(a ^ b);
         2'd2:    return a ^ t[2*W-1:W];
         default: return (clr ? '0 : macc) ^ a ^ b;
      endcase
   endfunction

   // Called at a falling edge with inputs already driven; advances one clock and checks.
   task automatic cycle();
      logic         a;
      logic         h;
      logic [W-1:0] f;
      a = in_valid && o_in_ready;
      h = o_out_valid && out_ready;
      f = model_f(mode, in0, in1, acc_clr);
      if (h) begin
         delivered.push_back(o_out_data);
         if (q.size() > 0) void'(q.pop_front());
         mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      if (a) q.push_back(f);
      if (a && mode == 2'd3) macc = f;
      else if (acc_clr) macc = '0;
      @(posedge clk);
      @(negedge clk);
      chk("xfer_cnt", o_xfer_cnt, mcnt);
      chk("out_valid", o_out_valid, q.size() != 0);
      chk("in_ready", o_in_ready, q.size() < 2);
      if (q.size() != 0) chk("out_data", o_out_data, q[0]);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && q.size() != 0; i++) cycle();
      chk("drain_empty", o_out_valid, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      acc_clr = 1'b0;
      q.delete();
      delivered.delete();
      macc = '0;
      mcnt = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 2'd0, 16'hA5A5, 16'h0FF0, 1'b0, 16'hAA55};
      tbl[1] = '{1'b1, 2'd1, 16'h1234, 16'h1234, 1'b0, 16'hFFFF};
      tbl[2] = '{1'b1, 2'd2, 16'h0000, 16'h8001, 1'b0, 16'h0006};
      tbl[3] = '{1'b1, 2'd3, 16'h0001, 16'h0000, 1'b1, 16'h0001};
      tbl[4] = '{1'b1, 2'd3, 16'h0002, 16'h0000, 1'b0, 16'h0003};
      tbl[5] = '{1'b1, 2'd3, 16'h0004, 16'h0001, 1'b0, 16'h0006};
      tbl[6] = '{1'b0, 2'd3, 16'h0000, 16'h0000, 1'b1, 16'h0000};
      tbl[7] = '{1'b1, 2'd3, 16'h00F0, 16'h0000, 1'b0, 16'h00F0};

      @(negedge clk);
      chk("rst_out_valid", o_out_valid, 1'b0);
      chk("rst_in_ready", o_in_ready, 1'b1);
      chk("rst_out_data", o_out_data, 16'h0000);
      chk("rst_xfer_cnt", o_xfer_cnt, 4'd0);
      do_reset();

      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = tbl[i].valid;
         mode     = tbl[i].mode;
         in0      = tbl[i].a;
         in1      = tbl[i].b;
         acc_clr  = tbl[i].clr;
         cycle();
         if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), o_out_data, tbl[i].exp);
      end
      drain();
      chk("tbl_xfer_cnt", o_xfer_cnt, 4'd7);

      delivered.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      mode      = 2'd0;
      in1       = 16'h0000;
      in0 = 16'h1111; cycle();
      in0 = 16'h2222; cycle();
      chk("bp_in_ready_low", o_in_ready, 1'b0);
      in0 = 16'h3333; cycle();
      chk("bp_hold_data", o_out_data, 16'h1111);
      out_ready = 1'b1;
      cycle();
      cycle();
      drain();
      chk("bp_count", delivered.size(), 3);
      if (delivered.size() == 3) begin
         chk("bp_order0", delivered[0], 16'h1111);
         chk("bp_order1", delivered[1], 16'h2222);
         chk("bp_order2", delivered[2], 16'h3333);
      end

      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      mode      = 2'd0;
      for (int i = 0; i < 17; i++) begin
         in0 = 16'(i);
         cycle();
      end
      drain();
      chk("wrap_xfer_cnt", o_xfer_cnt, 4'd1);

      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         acc_clr   = ($urandom_range(0, 9) == 0);
         mode      = 2'($urandom_range(0, 3));
         in0       = 16'($urandom);
         in1       = 16'($urandom);
         cycle();
      end
      drain();

      in_valid  = 1'b1;
      out_ready = 1'b0;
      mode      = 2'd3;
      in0 = 16'h5555; in1 = 16'h00FF; cycle();
      in0 = 16'hAAAA; cycle();
      chk("pre_rst_full", o_in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", o_out_valid, 1'b0);
      chk("mid_rst_in_ready", o_in_ready, 1'b1);
      chk("mid_rst_xfer_cnt", o_xfer_cnt, 4'd0);
      q.delete();
      macc = '0;
      mcnt = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      acc_clr   = 1'b0;
      mode      = 2'd3;
      in0 = 16'h0F0F; in1 = 16'h0101;
      cycle();
      chk("post_rst_acc", o_out_data, 16'h0E0E);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
